// File: rtl/arc_pkg.sv
// Shared types and screen defaults for the midpoint circle engine.
package arc_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef logic signed [9:0] coord_t;
    typedef logic [2:0]        oct_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLOT,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/arc_octant_map.sv
// Maps the current (off_x, off_y) offset into one of the eight symmetric
// octant positions and decides whether that pixel is enabled and on screen.
module arc_octant_map
    import arc_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  coord_t     cx,
    input  coord_t     cy,
    input  coord_t     off_x,
    input  coord_t     off_y,
    input  oct_t       oct,
    input  logic [7:0] mask,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic       in_bounds_and_enabled
);

    coord_t w_px;
    coord_t w_py;
    logic   w_x_ok;
    logic   w_y_ok;

    always_comb begin
        w_px = cx;
        w_py = cy;
        case (oct)
            3'd0: begin w_px = cx + off_x; w_py = cy + off_y; end
            3'd1: begin w_px = cx + off_y; w_py = cy + off_x; end
            3'd2: begin w_px = cx - off_y; w_py = cy + off_x; end
            3'd3: begin w_px = cx - off_x; w_py = cy + off_y; end
            3'd4: begin w_px = cx - off_x; w_py = cy - off_y; end
            3'd5: begin w_px = cx - off_y; w_py = cy - off_x; end
            3'd6: begin w_px = cx + off_y; w_py = cy - off_x; end
            3'd7: begin w_px = cx + off_x; w_py = cy - off_y; end
            default: begin w_px = cx; w_py = cy; end
        endcase
    end

    // Sign bit clear means non-negative; upper bound is a signed compare.
    assign w_x_ok = !w_px[9] && (w_px < coord_t'(SCREEN_W));
    assign w_y_ok = !w_py[9] && (w_py < coord_t'(SCREEN_H));

    assign in_bounds_and_enabled = mask[oct] && w_x_ok && w_y_ok;
    assign px = w_px[7:0];
    assign py = w_py[6:0];

endmodule

// File: rtl/arc_circle.sv
// Midpoint circle engine: one octant plot slot per clock, clipped to the
// screen and filtered by octant_mask, with a level start/done handshake.
module arc_circle
    import arc_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour,
    input  logic [7:0] octant_mask,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_t     r_state;
    coord_t     r_cx;
    coord_t     r_cy;
    coord_t     r_off_x;
    coord_t     r_off_y;
    coord_t     r_crit;
    oct_t       r_oct;
    logic [7:0] r_radius;
    logic [2:0] r_colour;
    logic [7:0] r_mask;

    logic [7:0] w_px;
    logic [6:0] w_py;
    logic       w_visible;
    logic       w_in_plot;
    coord_t     w_next_x;
    coord_t     w_next_y;
    coord_t     w_next_crit;
    logic       w_crit_le0;

    arc_octant_map #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_map (
        .cx                    (r_cx),
        .cy                    (r_cy),
        .off_x                 (r_off_x),
        .off_y                 (r_off_y),
        .oct                   (r_oct),
        .mask                  (r_mask),
        .px                    (w_px),
        .py                    (w_py),
        .in_bounds_and_enabled (w_visible)
    );

    assign w_crit_le0 = r_crit[9] || (r_crit == '0);

    always_comb begin
        w_next_y    = r_off_y + coord_t'(1);
        w_next_x    = r_off_x;
        w_next_crit = r_crit + {w_next_y[8:0], 1'b0} + coord_t'(1);
        if (!w_crit_le0) begin
            w_next_x    = r_off_x - coord_t'(1);
            w_next_crit = r_crit + coord_t'({w_next_y - w_next_x, 1'b0}) + coord_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cx     <= '0;
            r_cy     <= '0;
            r_off_x  <= '0;
            r_off_y  <= '0;
            r_crit   <= '0;
            r_oct    <= '0;
            r_radius <= '0;
            r_colour <= '0;
            r_mask   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cx     <= coord_t'({2'b00, centre_x});
                        r_cy     <= coord_t'({3'b000, centre_y});
                        r_radius <= radius;
                        r_colour <= colour;
                        r_mask   <= octant_mask;
                        r_state  <= INIT;
                    end
                end
                INIT: begin
                    r_off_x <= coord_t'({2'b00, r_radius});
                    r_off_y <= '0;
                    r_crit  <= coord_t'(1) - coord_t'({2'b00, r_radius});
                    r_oct   <= '0;
                    r_state <= PLOT;
                end
                PLOT: begin
                    r_oct <= r_oct + oct_t'(1);
                    if (r_oct == oct_t'(7)) begin
                        r_state <= STEP;
                    end
                end
                STEP: begin
                    r_off_x <= w_next_x;
                    r_off_y <= w_next_y;
                    r_crit  <= w_next_crit;
                    r_oct   <= '0;
                    r_state <= (w_next_y <= w_next_x) ? PLOT : DONE;
                end
                DONE: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pixel outputs decode straight from the state registers so the adapter
    // sees the slot in the same cycle, and reset kills the strobe at once.
    assign w_in_plot  = (r_state == PLOT);
    assign vga_plot   = w_in_plot && w_visible;
    assign vga_x      = w_in_plot ? w_px : '0;
    assign vga_y      = w_in_plot ? w_py : '0;
    assign vga_colour = w_in_plot ? r_colour : '0;
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_arc_circle.sv
// Directed bench for arc_circle: plotted pixel lists, done latency, clipping,
// masking, reset abort and input-ignore behaviour.
module tb_arc_circle;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic [7:0] octant_mask;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_cmp;
    int n_bad;
    int plot_q[$];
    int exp_q[$];
    int lat;

    arc_circle #(
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .colour      (colour),
        .octant_mask (octant_mask),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int enc(input int c, input int x, input int y);
        return (c << 16) | (x << 8) | y;
    endfunction

    always @(negedge clk) begin
        if (vga_plot) plot_q.push_back(enc(int'(vga_colour), int'(vga_x), int'(vga_y)));
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic add_pt(input int c, input int x, input int y);
        exp_q.push_back(enc(c, x, y));
    endtask

    task automatic check_plots(input string tag);
        int n;
        check_eq({tag, ".count"}, plot_q.size(), exp_q.size());
        n = (plot_q.size() < exp_q.size()) ? plot_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++)
            check_eq($sformatf("%s.pt%0d", tag, i), plot_q[i], exp_q[i]);
    endtask

    // Starts a draw and returns edges from the start-sampling edge until done
    // is first sampled high; -1 if the cycle budget runs out.
    task automatic run_draw(input int cx, input int cy, input int r, input int c,
                            input int m, input bit perturb, output int latency);
        int  cnt;
        bit  seen;
        logic [31:0] v;
        @(negedge clk);
        plot_q.delete();
        v = cx; centre_x = v[7:0];
        v = cy; centre_y = v[6:0];
        v = r;  radius   = v[7:0];
        v = c;  colour   = v[2:0];
        v = m;  octant_mask = v[7:0];
        start = 1'b1;
        @(posedge clk);
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 600 && !seen) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (perturb && cnt == 4) begin
                centre_x = 8'd10; centre_y = 7'd10; radius = 8'd3;
                octant_mask = 8'hFF; colour = 3'd7; start = 1'b0;
            end
            if (perturb && cnt == 6) start = 1'b1;
            seen = done;
        end
        latency = seen ? cnt + 1 : -1;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic exp_r1(input int c);
        exp_q.delete();
        add_pt(c, 81, 60); add_pt(c, 80, 61); add_pt(c, 80, 61); add_pt(c, 79, 60);
        add_pt(c, 79, 60); add_pt(c, 80, 59); add_pt(c, 80, 59); add_pt(c, 81, 60);
        add_pt(c, 81, 61); add_pt(c, 81, 61); add_pt(c, 79, 61); add_pt(c, 79, 61);
        add_pt(c, 79, 59); add_pt(c, 79, 59); add_pt(c, 81, 59); add_pt(c, 81, 59);
    endtask

    task automatic exp_r5_oct0(input int c);
        exp_q.delete();
        add_pt(c, 85, 60); add_pt(c, 85, 61); add_pt(c, 85, 62); add_pt(c, 84, 63);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        centre_x = '0; centre_y = '0; radius = '0; colour = '0; octant_mask = '0;
        #12;
        check_eq("reset.done", int'(done), 0);
        check_eq("reset.plot", int'(vga_plot), 0);
        check_eq("reset.x", int'(vga_x), 0);
        check_eq("reset.y", int'(vga_y), 0);
        check_eq("reset.colour", int'(vga_colour), 0);
        @(negedge clk);
        rst = 1'b0;

        // r=0: eight plots at the centre, done held while start is held
        exp_q.delete();
        for (int unsigned i = 0; i < 8; i++) add_pt(5, 80, 60);
        run_draw(80, 60, 0, 5, 8'hFF, 1'b0, lat);
        check_eq("r0.latency", lat, 11);
        check_plots("r0");
        repeat (3) @(negedge clk);
        check_eq("r0.done_held", int'(done), 1);
        check_eq("r0.no_replot", plot_q.size(), 8);
        release_start();
        check_eq("r0.done_clear", int'(done), 0);

        // r=1: two iterations
        exp_r1(3);
        run_draw(80, 60, 1, 3, 8'hFF, 1'b0, lat);
        check_eq("r1.latency", lat, 20);
        check_plots("r1");
        release_start();

        // r=5 with only octant 0 enabled, then all octants: same latency
        exp_r5_oct0(2);
        run_draw(80, 60, 5, 2, 8'h01, 1'b0, lat);
        check_eq("r5m01.latency", lat, 38);
        check_plots("r5m01");
        release_start();
        run_draw(80, 60, 5, 2, 8'hFF, 1'b0, lat);
        check_eq("r5mFF.latency", lat, 38);
        check_eq("r5mFF.count", plot_q.size(), 32);
        release_start();

        // corner centre: only first-quadrant pixels survive clipping
        exp_q.delete();
        add_pt(7, 10, 0); add_pt(7, 0, 10); add_pt(7, 0, 10); add_pt(7, 10, 0);
        add_pt(7, 10, 1); add_pt(7, 1, 10); add_pt(7, 10, 2); add_pt(7, 2, 10);
        add_pt(7, 10, 3); add_pt(7, 3, 10); add_pt(7, 9, 4);  add_pt(7, 4, 9);
        add_pt(7, 9, 5);  add_pt(7, 5, 9);  add_pt(7, 8, 6);  add_pt(7, 6, 8);
        add_pt(7, 7, 7);  add_pt(7, 7, 7);
        run_draw(0, 0, 10, 7, 8'hFF, 1'b0, lat);
        check_eq("corner.latency", lat, 74);
        check_plots("corner");
        release_start();

        // asynchronous reset in the middle of an r=40 draw
        @(negedge clk);
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd1;
        octant_mask = 8'hFF; start = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check_eq("abort.plot_before", int'(vga_plot), 1);
        #1 rst = 1'b1;
        #1;
        check_eq("abort.plot", int'(vga_plot), 0);
        check_eq("abort.done", int'(done), 0);
        check_eq("abort.x", int'(vga_x), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        plot_q.delete();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("abort.no_plots", plot_q.size(), 0);
        check_eq("abort.idle_done", int'(done), 0);
        exp_r1(4);
        run_draw(80, 60, 1, 4, 8'hFF, 1'b0, lat);
        check_eq("abort.redraw_latency", lat, 20);
        check_plots("abort.redraw");
        release_start();

        // inputs changed and start re-pulsed mid-draw are ignored
        exp_r5_oct0(2);
        run_draw(80, 60, 5, 2, 8'h01, 1'b1, lat);
        check_eq("ignore.latency", lat, 38);
        check_plots("ignore");
        release_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
